trig_burst_gen: RTL and testbench
=================================

Name: trig_burst_gen

Overview:
- Programmable trigger source; sits directly upstream of the pulse delay stage and drives its trigger input.
- Emits a burst of `count` rectangular pulses, or runs continuously, with programmable period and high time.
- Time unit is one clk cycle (10 ns at 100 MHz).
- Configuration is latched on start, so the downstream delay stage sees stable, glitch-free edges.

Parameters:
- N, 32, width of the period and high_time fields (clk cycles).
- CNT_W, 16, width of the burst count and pulse index.

Ports:
- clk  input  1  system clock, 100 MHz
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle strobe, clk domain; begins a burst
- stop  input  1  single-cycle strobe, clk domain; aborts a burst
- period  input  N  pulse period in cycles, sampled on accepted start
- high_time  input  N  high phase in cycles, sampled on accepted start
- count  input  CNT_W  pulses per burst, sampled on accepted start; 0 = continuous
- trig_out  output  1  registered trigger to the delay stage
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse when a burst completes normally
- pulse_idx  output  CNT_W  index of the current pulse, 0-based

Behaviour:
- Reset (reset_n low, asynchronous):
  - trig_out=0, busy=0, done=0, pulse_idx=0.
  - FSM goes to IDLE; all internal counters and latched config are cleared.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - start=1 and stop=0: latch config, set phase counter to 0, go to HIGH.
  - busy=1 and trig_out=1 from the next cycle, so output latency is 1 cycle from start.
- Config sanitising, applied at latch time:
  - eff_period = max(period, 2).
  - eff_high = high_time==0 ? 1 : min(high_time, eff_period-1).
  - trig_out therefore always has at least one low cycle, so the downstream edge detector sees every edge.
- HIGH:
  - trig_out=1; the phase counter increments each cycle.
  - When phase == eff_high-1, go to LOW.
- LOW:
  - trig_out=0; the phase counter increments.
  - At phase == eff_period-1:
    - If count!=0 and pulse_idx==count-1: go to IDLE, busy=0, done=1 for exactly one cycle.
    - Otherwise: pulse_idx+1, phase=0, go to HIGH.
- Period is exact: rising edges of trig_out are exactly eff_period cycles apart.
- Continuous mode (count=0):
  - pulse_idx wraps from 2^CNT_W-1 to 0 with no side effects.
  - Only stop or reset terminates it.
- stop while busy:
  - trig_out=0, busy=0 on the next clock; go to IDLE, no done pulse.
  - pulse_idx holds its last value until the next start.
- start while busy: ignored; config and counters are unaffected.
- start and stop in the same cycle:
  - stop wins.
  - From IDLE, neither has any effect.
- Input changes on period/high_time/count mid-burst have no effect until the next accepted start.
- Width rules: the phase counter is N bits, compared against eff_* (N bits); no overflow is possible because phase < eff_period.
- reset_n deasserted mid-burst: outputs drop asynchronously; no partial pulse resumes after reset.

Optional Feature:
- Macro: TRIG_EXT_GATE_EN.
- Defined:
  - Adds input `gate` (1 bit, clk domain, active high).
  - While gate=0 in HIGH or LOW: the phase counter and pulse_idx freeze, and trig_out is forced 0.
  - When gate returns to 1, trig_out resumes at its pre-gate level on the next cycle, and counting continues from the frozen phase.
  - busy stays 1 throughout.
  - stop and reset act normally while gated.
- Not defined: no gate port; behaviour is as if gate=1 always.

Decomposition:
- Shared package pdl_pkg:
  - State enum trig_state_t {IDLE, HIGH, LOW}.
  - Constants TRIG_MIN_PERIOD=2 and TRIG_MIN_HIGH=1.
  - Default widths N and CNT_W.
- One sub-module: trig_cfg_sanitize.
  - Combinational; maps the raw period and high_time to eff_period and eff_high.
  - Reused by the delay stage's own config path.
- FSM, counters and output register stay in trig_burst_gen.

Test Plan:
- Basic burst: period=10, high_time=3, count=4, start pulse.
  - trig_out rises 1 cycle later.
  - 4 pulses, each 3 high / 7 low.
  - done pulses 1 cycle after the last low phase ends.
  - busy spans exactly 40 cycles.
- Sanitising:
  - period=1, high_time=0, count=2: 1-high/1-low pulses, period 2.
  - period=5, high_time=9: eff_high=4, 4 high / 1 low.
- Abort: count=0 (continuous), period=8, high_time=2, stop in pulse 3 during HIGH.
  - trig_out=0 and busy=0 next cycle; no done; pulse_idx stays 2.
- Collisions:
  - start during a burst: ignored; period unchanged.
  - start+stop same cycle from IDLE: nothing happens.
  - stop+start while busy: abort only.
- Async reset: reset_n low mid-HIGH, between clock edges.
  - trig_out, busy and pulse_idx go to 0 immediately.
  - After release, no activity until a new start.
- TRIG_EXT_GATE_EN: period=10, high_time=5, gate low for 6 cycles at phase 2.
  - trig_out is 0 during the gap.
  - The remaining 3 high cycles resume; the burst end is shifted by exactly 6 cycles.

Source files
------------

// File: rtl/pdl_pkg.sv
// pdl_pkg: shared state type, config limits and default widths for the trigger and pulse delay stages
package pdl_pkg;
    localparam int TRIG_N          = 32;
    localparam int TRIG_CNT_W      = 16;
    localparam int TRIG_MIN_PERIOD = 2;
    localparam int TRIG_MIN_HIGH   = 1;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} trig_state_t;
endpackage

// File: rtl/trig_cfg_sanitize.sv
// trig_cfg_sanitize: clamps raw period/high_time so every pulse has at least one high and one low cycle
module trig_cfg_sanitize
    import pdl_pkg::*;
#(
    parameter int N = TRIG_N
) (
    input  logic [N-1:0] period,
    input  logic [N-1:0] high_time,
    output logic [N-1:0] eff_period,
    output logic [N-1:0] eff_high
);
    always_comb begin
        eff_period = period < N'(TRIG_MIN_PERIOD) ? N'(TRIG_MIN_PERIOD) : period;
        eff_high   = high_time == '0 ? N'(TRIG_MIN_HIGH) :
                     high_time > eff_period - N'(1) ? eff_period - N'(1) : high_time;
    end
endmodule

// File: rtl/trig_burst_gen.sv
// trig_burst_gen: burst/continuous trigger pulse generator; TRIG_EXT_GATE_EN adds a gate input that pauses the burst
module trig_burst_gen
    import pdl_pkg::*;
#(
    parameter int N     = TRIG_N,
    parameter int CNT_W = TRIG_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
`ifdef TRIG_EXT_GATE_EN
    input  logic             gate,
`endif
    input  logic [N-1:0]     period,
    input  logic [N-1:0]     high_time,
    input  logic [CNT_W-1:0] count,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);
    trig_state_t      state, nxt;
    logic [N-1:0]     phase, phase_nxt, cfg_period, cfg_high, san_period, san_high;
    logic [CNT_W-1:0] cfg_count, idx_nxt;
    logic             done_nxt, gate_on, accept;

`ifdef TRIG_EXT_GATE_EN
    assign gate_on = gate;
`else
    assign gate_on = 1'b1;
`endif

    trig_cfg_sanitize #(.N(N)) u_sanitize (
        .period    (period),
        .high_time (high_time),
        .eff_period(san_period),
        .eff_high  (san_high)
    );

    assign accept = state == IDLE && start && !stop;

    always_comb begin
        nxt       = state;
        phase_nxt = phase;
        idx_nxt   = pulse_idx;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (accept) begin
                nxt       = HIGH;
                phase_nxt = '0;
                idx_nxt   = '0;
            end
        end else if (stop) begin
            nxt = IDLE;
        end else if (gate_on) begin
            phase_nxt = phase + N'(1);
            if (state == HIGH && phase == cfg_high - N'(1)) begin
                nxt = LOW;
            end else if (state == LOW && phase == cfg_period - N'(1)) begin
                phase_nxt = '0;
                if (cfg_count != '0 && pulse_idx == cfg_count - CNT_W'(1)) begin
                    nxt      = IDLE;
                    done_nxt = 1'b1;
                end else begin
                    nxt     = HIGH;
                    idx_nxt = pulse_idx + CNT_W'(1);
                end
            end
        end
    end

    // outputs are registered from the next state so the delay stage sees clean edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= '0;
            pulse_idx  <= '0;
            cfg_period <= '0;
            cfg_high   <= '0;
            cfg_count  <= '0;
            trig_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= nxt;
            phase     <= phase_nxt;
            pulse_idx <= idx_nxt;
            trig_out  <= nxt == HIGH && (gate_on || state == IDLE);
            busy      <= nxt != IDLE;
            done      <= done_nxt;
            if (accept) begin
                cfg_period <= san_period;
                cfg_high   <= san_high;
                cfg_count  <= count;
            end
        end
    end
endmodule

// File: tb/tb_trig_burst_gen.sv
// tb_trig_burst_gen: random and directed stimulus against a closed-form burst timing model via a per-cycle scoreboard
module tb_trig_burst_gen;
    typedef struct {
        int          cyc;
        logic        trig;
        logic        busy;
        logic        done;
        logic [15:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period = '0;
    logic [31:0] high_time = '0;
    logic [15:0] count = '0;
    logic        trig_out, busy, done;
    logic [15:0] pulse_idx;
`ifdef TRIG_EXT_GATE_EN
    logic        gate = 1'b1;
`endif

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    bit          m_active = 0;
    int          m_s, m_p, m_h, m_c;
    logic [15:0] m_idx = '0;

    trig_burst_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
`ifdef TRIG_EXT_GATE_EN
        .gate     (gate),
`endif
        .period   (period),
        .high_time(high_time),
        .count    (count),
        .trig_out (trig_out),
        .busy     (busy),
        .done     (done),
        .pulse_idx(pulse_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output after edge t: pulses are laid out back to back from the start edge,
    // so pulse number and phase follow from the elapsed cycles alone.
    task automatic model(input logic st, input logic sp, input int per, input int hi, input int cnt, input int t);
        exp_t e;
        int   k, pulse;
        e.cyc = t; e.trig = 0; e.busy = 0; e.done = 0; e.idx = m_idx;
        if (m_active && sp) begin
            m_active = 0;
        end else if (!m_active && st && !sp) begin
            m_active = 1;
            m_s = t;
            m_p = per < 2 ? 2 : per;
            m_h = hi == 0 ? 1 : (hi > m_p - 1 ? m_p - 1 : hi);
            m_c = cnt;
        end
        if (m_active) begin
            k = t - m_s;
            pulse = k / m_p;
            if (m_c == 0 || pulse < m_c) begin
                e.busy = 1;
                e.trig = (k % m_p) < m_h;
                e.idx  = 16'(pulse);
            end else begin
                m_active = 0;
                e.done = 1;
                e.idx  = 16'(m_c - 1);
            end
        end
        m_idx = e.idx;
        q.push_back(e);
    endtask

    task automatic step(input logic st, input logic sp, input int per, input int hi, input int cnt);
        @(posedge clk);
        #1;
        start = st; stop = sp; period = per; high_time = hi; count = 16'(cnt);
        model(st, sp, per, hi, cnt, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 5));
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (trig_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pulse_idx !== 16'd0) begin
            miscompares++;
            $display("FAIL %s: got trig=%b busy=%b done=%b idx=%0d, want all zero", name, trig_out, busy, done, pulse_idx);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 0; start = 0; stop = 0;
        #1;
        check_zero("async_reset");
        q.delete();
        m_active = 0;
        m_idx = '0;
        @(negedge clk);
        #1;
        reset_n = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            vectors++;
            if (e.cyc != cyc || trig_out !== e.trig || busy !== e.busy || done !== e.done || pulse_idx !== e.idx) begin
                miscompares++;
                $display("FAIL cyc%0d (vec for %0d): got trig=%b busy=%b done=%b idx=%0d, want trig=%b busy=%b done=%b idx=%0d",
                         cyc, e.cyc, trig_out, busy, done, pulse_idx, e.trig, e.busy, e.done, e.idx);
            end
        end
    end

    initial begin
        #2;
        check_zero("reset_state");
        @(negedge clk);
        #1;
        reset_n = 1;
        idle(3);
        step(1, 0, 10, 3, 4);  idle(45);
        step(1, 0, 1, 0, 2);   idle(6);
        step(1, 0, 5, 9, 1);   idle(7);
        step(1, 0, 8, 2, 0);   idle(16);
        step(0, 1, 8, 2, 0);   idle(4);
        step(1, 0, 6, 2, 2);   idle(2);
        step(1, 0, 3, 1, 5);   idle(15);
        step(1, 1, 4, 1, 1);   idle(3);
        step(1, 0, 8, 3, 0);   idle(3);
        step(1, 1, 4, 1, 1);   idle(3);
        step(1, 0, 10, 5, 3);  idle(2);
        async_reset();
        idle(6);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 5));
        step(0, 1, 4, 1, 1);
        idle(2);
        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end
endmodule
